// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - 4-digit 7-segment scanner for CPU state with debounced step button
module seg_display_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [1:0]  sel,
    input  logic        btn_in,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    input  logic [31:0] rt_data,
    input  logic [31:0] alu_result,
    input  logic [31:0] db_data,
    output logic        step_pulse,
    output logic [3:0]  pos_ctrl,
    output logic [7:0]  num_ctrl
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // Scan / display state
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [7:0]        snap_l_q, snap_r_q;
    logic              load_pending_q;
    logic [3:0]        pos_ctrl_q, pos_d;
    logic [7:0]        num_ctrl_q, num_d;

    // Debounce state
    logic              sync0_q, sync1_q;
    logic              stable_q, stable_prev_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              step_pulse_q;

    logic [7:0]        page_l, page_r;
    logic [3:0]        nibble;
    logic              scan_last;
    logic              frame_wrap;

    // Only the low byte of each 32-bit bus is ever shown
    logic unused_bits;
    assign unused_bits = ^{pc[31:8], next_pc[31:8], rs_data[31:8],
                           rt_data[31:8], alu_result[31:8], db_data[31:8]};

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Page select: which pair of bytes is offered to the snapshot
    always_comb begin
        page_l = 8'h00;
        page_r = 8'h00;
        case (sel)
            2'b00: begin page_l = pc[7:0];            page_r = next_pc[7:0];    end
            2'b01: begin page_l = {3'b000, rs_addr};  page_r = rs_data[7:0];    end
            2'b10: begin page_l = {3'b000, rt_addr};  page_r = rt_data[7:0];    end
            default: begin page_l = alu_result[7:0];  page_r = db_data[7:0];    end
        endcase
    end

    assign scan_last   = (scan_cnt_q == SCAN_LAST);
    assign frame_wrap  = scan_last && (digit_idx_q == 2'd3);
    assign scan_cnt_d  = scan_last ? '0 : scan_cnt_q + SCAN_W'(1);
    assign digit_idx_d = scan_last ? digit_idx_q + 2'd1 : digit_idx_q;

    // Digit enable and nibble for the digit currently being scanned
    always_comb begin
        nibble = snap_r_q[3:0];
        pos_d  = 4'b1110;
        case (digit_idx_q)
            2'd3: begin nibble = snap_l_q[7:4]; pos_d = 4'b0111; end
            2'd2: begin nibble = snap_l_q[3:0]; pos_d = 4'b1011; end
            2'd1: begin nibble = snap_r_q[7:4]; pos_d = 4'b1101; end
            default: begin nibble = snap_r_q[3:0]; pos_d = 4'b1110; end
        endcase
        // Decimal point separates the two bytes, so it sits on idx2
        num_d = {(digit_idx_q != 2'd2), hex7(nibble)};
    end

    // Scan counter, frame snapshot and registered digit drive
    always_ff @(posedge clk) begin
        if (RST) begin
            scan_cnt_q     <= '0;
            digit_idx_q    <= 2'd0;
            snap_l_q       <= 8'h00;
            snap_r_q       <= 8'h00;
            load_pending_q <= 1'b1;
            pos_ctrl_q     <= 4'b1111;
            num_ctrl_q     <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            if (load_pending_q || frame_wrap) begin
                snap_l_q       <= page_l;
                snap_r_q       <= page_r;
                load_pending_q <= 1'b0;
            end
            // Stay blank until the first snapshot holds real data
            if (load_pending_q) begin
                pos_ctrl_q <= 4'b1111;
                num_ctrl_q <= 8'hFF;
            end else begin
                pos_ctrl_q <= pos_d;
                num_ctrl_q <= num_d;
            end
        end
    end

    // Button synchronizer, debounce counter and rising-edge step pulse
    always_ff @(posedge clk) begin
        if (RST) begin
            sync0_q       <= 1'b0;
            sync1_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            step_pulse_q  <= 1'b0;
        end else begin
            sync0_q       <= btn_in;
            sync1_q       <= sync0_q;
            stable_prev_q <= stable_q;
            step_pulse_q  <= stable_q && !stable_prev_q;
            if (sync1_q != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_q <= sync1_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign pos_ctrl   = pos_ctrl_q;
    assign num_ctrl   = num_ctrl_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - self-checking bench for seg_display_scanner
module tb_seg_display_scanner;
    localparam int SD      = 4;
    localparam int DB      = 8;
    localparam int FRAME   = 4 * SD;
    // Edges from the btn_in drive to the visible pulse
    localparam int BTN_LAT = DB + 3;
    // Edges after the first edge that samples RST low
    localparam int RST_LAT = DB + 2;

    logic        clk = 1'b0;
    logic        RST;
    logic [1:0]  sel;
    logic        btn_in;
    logic [31:0] pc, next_pc, rs_data, rt_data, alu_result, db_data;
    logic [4:0]  rs_addr, rt_addr;
    logic        step_pulse;
    logic [3:0]  pos_ctrl;
    logic [7:0]  num_ctrl;

    seg_display_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .RST(RST), .sel(sel), .btn_in(btn_in),
        .pc(pc), .next_pc(next_pc), .rs_addr(rs_addr), .rs_data(rs_data),
        .rt_addr(rt_addr), .rt_data(rt_data), .alu_result(alu_result),
        .db_data(db_data), .step_pulse(step_pulse), .pos_ctrl(pos_ctrl),
        .num_ctrl(num_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       sel;
        logic [31:0]      pc, next_pc;
        logic [4:0]       rs_addr;
        logic [31:0]      rs_data;
        logic [4:0]       rt_addr;
        logic [31:0]      rt_data, alu, db;
        logic [3:0][7:0]  exp;    // expected num_ctrl per digit index
    } vec_t;

    typedef struct {
        logic [3:0] pos;
        logic [7:0] num;
        logic       step;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   t_m = 0;
    int   cur_vec = 0;
    int   snap_vec = 0;

    function automatic vec_t mk(input logic [1:0] s, input logic [31:0] p, input logic [31:0] np,
                                input logic [4:0] ra, input logic [31:0] rd,
                                input logic [4:0] ta, input logic [31:0] td,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.sel = s; v.pc = p; v.next_pc = np; v.rs_addr = ra; v.rs_data = rd;
        v.rt_addr = ta; v.rt_data = td; v.alu = a; v.db = d; v.exp = e;
        return v;
    endfunction

    task automatic apply(input int v);
        sel = vecs[v].sel; pc = vecs[v].pc; next_pc = vecs[v].next_pc;
        rs_addr = vecs[v].rs_addr; rs_data = vecs[v].rs_data;
        rt_addr = vecs[v].rt_addr; rt_data = vecs[v].rt_data;
        alu_result = vecs[v].alu; db_data = vecs[v].db;
        cur_vec = v;
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty t=%0d", t_m);
            return;
        end
        e = sbq.pop_front();
        checks++;
        if (pos_ctrl !== e.pos) begin
            errors++;
            $display("FAIL pos_ctrl t=%0d got=%b want=%b", t_m, pos_ctrl, e.pos);
        end
        checks++;
        if (num_ctrl !== e.num) begin
            errors++;
            $display("FAIL num_ctrl t=%0d got=%h want=%h", t_m, num_ctrl, e.num);
        end
        checks++;
        if (step_pulse !== e.step) begin
            errors++;
            $display("FAIL step_pulse t=%0d got=%b want=%b", t_m, step_pulse, e.step);
        end
    endtask

    // Predict the outputs after the next edge, push them, then clock and compare
    task automatic tick(input logic exp_step);
        exp_t e;
        int idx;
        if (RST) begin
            e.pos = 4'hF; e.num = 8'hFF; e.step = 1'b0;
            t_m = 0;
        end else begin
            t_m++;
            if (t_m == 1) begin
                e.pos = 4'hF; e.num = 8'hFF;
            end else begin
                idx   = ((t_m - 1) / SD) % 4;
                e.pos = ~(4'b0001 << idx);
                e.num = vecs[snap_vec].exp[idx];
            end
            e.step = exp_step;
            if (t_m == 1 || (t_m % FRAME) == 0) snap_vec = cur_vec;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic ticks(input int n, input int pulse_at);
        for (int i = 1; i <= n; i++) tick(i == pulse_at);
    endtask

    initial begin
        vecs[0] = mk(2'b00, 32'h0000_0012, 32'h0000_0016, 5'd7,  32'hDEAD_BEEF, 5'd9, 32'h0000_0055,
                     32'h0000_0077, 32'h0000_0099, 32'hF9_24_F9_82);
        vecs[1] = mk(2'b11, 32'h0000_0012, 32'h0000_0016, 5'd7,  32'hDEAD_BEEF, 5'd9, 32'h0000_0055,
                     32'h0000_00AB, 32'h0000_00CD, 32'h88_03_C6_A1);
        vecs[2] = mk(2'b01, 32'h0000_0033, 32'h0000_0044, 5'd31, 32'h0000_0100, 5'd9, 32'h0000_0055,
                     32'h0000_0077, 32'h0000_0099, 32'hF9_0E_C0_C0);
        vecs[3] = mk(2'b10, 32'h0000_0033, 32'h0000_0044, 5'd31, 32'h0000_0100, 5'd5, 32'hFFFF_FF3E,
                     32'h0000_0077, 32'h0000_0099, 32'hC0_12_B0_86);
        vecs[4] = mk(2'b00, 32'hFFFF_FF47, 32'h0000_0089, 5'd2,  32'h0000_0011, 5'd5, 32'h0000_003E,
                     32'h0000_0077, 32'h0000_0099, 32'h99_78_80_90);
        vecs[5] = mk(2'b11, 32'hFFFF_FF47, 32'h0000_0089, 5'd2,  32'h0000_0011, 5'd5, 32'h0000_003E,
                     32'h0000_00E5, 32'h1234_56D0, 32'h86_12_A1_C0);

        RST = 1'b1;
        btn_in = 1'b0;
        apply(0);
        ticks(2, 0);
        RST = 1'b0;

        // Scan order, dwell and digit values on the first page
        ticks(40, 0);

        // Mid-frame page/data changes only show after the frame wraps
        for (int v = 1; v < 6; v++) begin
            ticks(5 + v, 0);
            apply(v);
            ticks(36, 0);
        end

        // Held button: one pulse, release gives none
        btn_in = 1'b1;
        ticks(20, BTN_LAT);
        btn_in = 1'b0;
        ticks(20, 0);

        // Bouncing button never settles long enough
        for (int r = 0; r < 4; r++) begin
            btn_in = 1'b1; ticks(5, 0);
            btn_in = 1'b0; ticks(2, 0);
        end
        ticks(12, 0);

        // Reset mid-frame with the button held
        btn_in = 1'b1;
        ticks(20, BTN_LAT);
        ticks(3, 0);
        RST = 1'b1;
        ticks(1, 0);
        RST = 1'b0;
        ticks(20, 1 + RST_LAT);
        btn_in = 1'b0;
        ticks(20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
